// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and parity mode constants.
// Also holds the baud-divider rounding helper used by the receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   function automatic int calc_div(
      input int clk_hz,
      input int baud,
      input int os
   );
      int step;
      int div;
      step = baud * os;
      div  = (clk_hz + step / 2) / step;
      if (div < 1) div = 1;
      return div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count.
// Head data reads as zero while empty; simultaneous push/pop when full is allowed.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];
   assign count   = cnt;

   // Storage array; written only on an accepted push.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority-vote bit decisions,
// parity/frame checking, sticky error flags and a receive FIFO.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 16000000,
   parameter int BAUD       = 19200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          data,
   output logic                          valid,
   input  logic                          ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   input  logic                          clear_err
);

   localparam int DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int DW   = $clog2(DIV + 1);
   localparam int SW   = $clog2(OVERSAMPLE);
   localparam int HALF = OVERSAMPLE / 2;

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [SW-1:0] SMP_A     = SW'(HALF - 1);
   localparam logic [SW-1:0] SMP_B     = SW'(HALF);
   localparam logic [SW-1:0] SMP_V     = SW'(HALF + 1);
   localparam logic [SW-1:0] SMP_END   = SW'(OVERSAMPLE - 1);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_prev;
   rx_state_t            state, state_n;
   logic [DW-1:0]        div_cnt, div_cnt_n;
   logic [SW-1:0]        smp_cnt, smp_cnt_n;
   logic                 s_a, s_a_n;
   logic                 s_b, s_b_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [3:0]           bit_cnt, bit_cnt_n;
   logic                 stop_idx, stop_idx_n;
   logic                 bad, bad_n;
   logic                 low_seen, low_seen_n;
   logic                 push_q, push_n;
   logic                 tick;
   logic                 at_vote;
   logic                 at_end;
   logic                 vote;
   logic                 fall;
   logic                 par_exp;
   logic                 frame_ev;
   logic                 parity_ev;
   logic                 overrun_ev;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign fall    = rx_prev & ~rx_sync;
   assign tick    = (state != ST_IDLE) && (div_cnt == DIV_LAST);
   assign at_vote = tick && (smp_cnt == SMP_V);
   assign at_end  = tick && (smp_cnt == SMP_END);
   assign vote    = (s_a & s_b) | (s_a & rx_sync) | (s_b & rx_sync);
   assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

   // Two-flop synchroniser plus a delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         div_cnt  <= '0;
         smp_cnt  <= '0;
         s_a      <= 1'b1;
         s_b      <= 1'b1;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_idx <= 1'b0;
         bad      <= 1'b0;
         low_seen <= 1'b0;
         push_q   <= 1'b0;
      end else begin
         state    <= state_n;
         div_cnt  <= div_cnt_n;
         smp_cnt  <= smp_cnt_n;
         s_a      <= s_a_n;
         s_b      <= s_b_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         stop_idx <= stop_idx_n;
         bad      <= bad_n;
         low_seen <= low_seen_n;
         push_q   <= push_n;
      end
   end

   // Next-state: tick divider, sample capture and frame sequencing.
   always_comb begin
      state_n    = state;
      div_cnt_n  = div_cnt;
      smp_cnt_n  = smp_cnt;
      s_a_n      = s_a;
      s_b_n      = s_b;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      stop_idx_n = stop_idx;
      bad_n      = bad;
      low_seen_n = low_seen;
      push_n     = 1'b0;
      frame_ev   = 1'b0;
      parity_ev  = 1'b0;

      if (state != ST_IDLE) begin
         div_cnt_n = tick ? '0 : div_cnt + DW'(1);
         if (tick) begin
            smp_cnt_n = at_end ? '0 : smp_cnt + SW'(1);
            if (smp_cnt == SMP_A) s_a_n = rx_sync;
            if (smp_cnt == SMP_B) s_b_n = rx_sync;
         end
      end

      unique case (state)
         ST_IDLE: begin
            if (fall) begin
               state_n    = ST_START;
               div_cnt_n  = '0;
               smp_cnt_n  = '0;
               bit_cnt_n  = '0;
               stop_idx_n = 1'b0;
               bad_n      = 1'b0;
            end
         end
         ST_START: begin
            if (at_vote && vote) state_n = ST_IDLE;
            else if (at_end)     state_n = ST_DATA;
         end
         ST_DATA: begin
            if (at_vote) shreg_n = {vote, shreg[DATA_BITS-1:1]};
            if (at_end) begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (at_vote && (vote != par_exp)) begin
               parity_ev = 1'b1;
               bad_n     = 1'b1;
            end
            if (at_end) state_n = ST_STOP;
         end
         ST_STOP: begin
            if (at_vote) begin
               if (!vote) begin
                  frame_ev   = 1'b1;
                  low_seen_n = 1'b1;
                  state_n    = ST_WAIT_HIGH;
               end else if (stop_idx == STOP_LAST) begin
                  state_n = ST_IDLE;
                  push_n  = ~bad;
               end
            end else if (at_end) begin
               stop_idx_n = 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            if (tick) begin
               if (!low_seen && rx_sync) state_n = ST_IDLE;
               low_seen_n = ~rx_sync;
            end else begin
               low_seen_n = low_seen | ~rx_sync;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign overrun_ev = push_q & fifo_full & ~ready;

   // Sticky error flags; a same-cycle event wins over clear_err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         frame_err  <= (frame_err  & ~clear_err) | frame_ev;
         parity_err <= (parity_err & ~clear_err) | parity_ev;
         overrun    <= (overrun    & ~clear_err) | overrun_ev;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_q),
      .pop   (ready),
      .wdata (shreg),
      .rdata (data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized UART frames checked by a queue scoreboard.
// Two receivers: no-parity main instance and an even-parity instance.
module tb_uart_rx_fifo;

   localparam int CLK_HZ = 16000000;
   localparam int BAUD   = 250000;
   localparam int OS     = 16;
   localparam int DEPTH  = 16;
   localparam int BITCLK = OS * ((CLK_HZ + BAUD * OS / 2) / (BAUD * OS));

   logic       clk;
   logic       reset;
   logic       rx, ready, clear_err;
   logic [7:0] data;
   logic       valid;
   logic [4:0] count;
   logic       frame_err, parity_err, overrun;

   logic       rx_p, ready_p, clear_err_p;
   logic [7:0] data_p;
   logic       valid_p;
   logic [4:0] count_p;
   logic       fe_p, pe_p, ov_p;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_qp[$];
   bit hold;
   bit ovr_exp;
   bit rnd_rdy;

   uart_rx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
      .ready(ready), .count(count), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun), .clear_err(clear_err)
   );

   uart_rx_fifo #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) dut_p (
      .clk(clk), .reset(reset), .rx(rx_p), .data(data_p), .valid(valid_p),
      .ready(ready_p), .count(count_p), .frame_err(fe_p),
      .parity_err(pe_p), .overrun(ov_p), .clear_err(clear_err_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic bit even_par(input logic [7:0] d);
      return 1'($countones(d) & 1);
   endfunction

   task automatic drive_bit(input int ln, input logic b);
      if (ln == 0) rx = b;
      else rx_p = b;
      step(BITCLK);
   endtask

   task automatic send(input int ln, input logic [7:0] d, input bit has_par,
                       input bit par_bit, input bit stop_bit);
      drive_bit(ln, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(ln, d[i]);
      if (has_par) drive_bit(ln, par_bit);
      drive_bit(ln, stop_bit);
      if (ln == 0) rx = 1'b1;
      else rx_p = 1'b1;
   endtask

   // Reference model: FIFO accepts unless it is full with no consumer.
   task automatic expect_main(input logic [7:0] d);
      if (hold && exp_q.size() == DEPTH) ovr_exp = 1'b1;
      else exp_q.push_back(d);
   endtask

   task automatic drain_main();
      int n;
      n = 0;
      ready = 1'b1;
      while ((exp_q.size() != 0 || valid) && n < 4000) begin
         step(1);
         n++;
      end
      chk("drain_main_timeout", 32'(n < 4000), 32'(1));
   endtask

   task automatic drain_p();
      int n;
      n = 0;
      while ((exp_qp.size() != 0 || valid_p) && n < 4000) begin
         step(1);
         n++;
      end
      chk("drain_par_timeout", 32'(n < 4000), 32'(1));
   endtask

   // Monitor for the main instance.
   initial forever begin
      @(negedge clk);
      if (reset && valid) begin
         if (ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_char: got 0x%0h expected none", data);
            end else begin
               chk("pop_data", 32'(data), 32'(exp_q.pop_front()));
            end
         end else if (exp_q.size() != 0) begin
            chk("head_stable", 32'(data), 32'(exp_q[0]));
         end
      end
   end

   // Monitor for the parity instance.
   initial forever begin
      @(negedge clk);
      if (reset && valid_p && ready_p) begin
         if (exp_qp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_par_char: got 0x%0h expected none", data_p);
         end else begin
            chk("pop_data_par", 32'(data_p), 32'(exp_qp.pop_front()));
         end
      end
   end

   // Random consumer back-pressure.
   initial forever begin
      @(posedge clk);
      #2;
      if (rnd_rdy) ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      rx = 1'b1; rx_p = 1'b1; ready = 1'b0; ready_p = 1'b1;
      clear_err = 1'b0; clear_err_p = 1'b0; reset = 1'b0;
      hold = 1'b0; ovr_exp = 1'b0; rnd_rdy = 1'b0;
      step(5);
      @(negedge clk);
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_valid", 32'(valid), 32'(0));
      chk("rst_data", 32'(data), 32'(0));
      chk("rst_frame", 32'(frame_err), 32'(0));
      chk("rst_parity", 32'(parity_err), 32'(0));
      chk("rst_overrun", 32'(overrun), 32'(0));
      reset = 1'b1;
      step(5);

      // Two characters held, then popped in order.
      hold = 1'b1;
      expect_main(8'h31); send(0, 8'h31, 0, 0, 1);
      expect_main(8'h32); send(0, 8'h32, 0, 0, 1);
      step(4);
      chk("two_count", 32'(count), 32'(exp_q.size()));
      chk("two_valid", 32'(valid), 32'(1));
      drain_main();
      hold = 1'b0;
      step(2);
      chk("two_valid_after", 32'(valid), 32'(0));

      // Glitch shorter than half a bit is a false start.
      ready = 1'b0;
      rx = 1'b0; step(3 * BITCLK / OS); rx = 1'b1;
      step(3 * BITCLK);
      chk("glitch_count", 32'(count), 32'(0));
      chk("glitch_frame", 32'(frame_err), 32'(0));
      chk("glitch_parity", 32'(parity_err), 32'(0));
      expect_main(8'h5A); send(0, 8'h5A, 0, 0, 1);
      drain_main();

      // Overrun: 17 characters into a 16-entry FIFO.
      ready = 1'b0;
      hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         expect_main(8'(i));
         send(0, 8'(i), 0, 0, 1);
         step(2);
      end
      step(4);
      chk("ovr_count", 32'(count), 32'(exp_q.size()));
      chk("ovr_flag", 32'(overrun), 32'(ovr_exp));
      drain_main();
      hold = 1'b0;
      ovr_exp = 1'b0;
      clear_err = 1'b1; step(1); clear_err = 1'b0; step(1);
      chk("ovr_clear", 32'(overrun), 32'(ovr_exp));

      // Frame error followed by a long break, then a good character.
      drive_bit(0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(0, d8(8'h55, i));
      rx = 1'b0;
      step(20 * BITCLK);
      chk("frm_flag", 32'(frame_err), 32'(1));
      chk("frm_count", 32'(count), 32'(0));
      rx = 1'b1;
      step(2 * BITCLK);
      expect_main(8'h41); send(0, 8'h41, 0, 0, 1);
      drain_main();
      chk("frm_sticky", 32'(frame_err), 32'(1));

      // Reset in the middle of bit 4 with one character queued.
      ready = 1'b0;
      hold = 1'b1;
      expect_main(8'h31); send(0, 8'h31, 0, 0, 1);
      step(4);
      chk("mid_count_pre", 32'(count), 32'(exp_q.size()));
      d = 8'h31;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
      rx = d[4];
      step(BITCLK / 2);
      reset = 1'b0;
      rx = 1'b1;
      exp_q.delete();
      hold = 1'b0;
      step(3);
      @(negedge clk);
      chk("mid_count", 32'(count), 32'(0));
      chk("mid_valid", 32'(valid), 32'(0));
      chk("mid_frame", 32'(frame_err), 32'(0));
      chk("mid_overrun", 32'(overrun), 32'(0));
      reset = 1'b1;
      step(2 * BITCLK);
      expect_main(8'h32); send(0, 8'h32, 0, 0, 1);
      drain_main();

      // Random characters against random back-pressure.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         expect_main(d);
         send(0, d, 0, 0, 1);
         step($urandom_range(0, 40));
      end
      rnd_rdy = 1'b0;
      step(1);
      drain_main();
      chk("rnd_overrun", 32'(overrun), 32'(0));
      chk("rnd_frame", 32'(frame_err), 32'(0));

      // Even parity: wrong parity bit is flagged and dropped.
      send(1, 8'h31, 1, ~even_par(8'h31), 1);
      step(4);
      chk("par_flag", 32'(pe_p), 32'(1));
      chk("par_count", 32'(count_p), 32'(0));
      clear_err_p = 1'b1; step(1); clear_err_p = 1'b0; step(1);
      chk("par_clear", 32'(pe_p), 32'(0));
      for (int i = 0; i < 5; i++) begin
         d = (i == 0) ? 8'h31 : 8'($urandom);
         exp_qp.push_back(d);
         send(1, d, 1, even_par(d), 1);
         step($urandom_range(0, 20));
      end
      drain_p();
      chk("par_clean", 32'(pe_p), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   function automatic logic d8(input logic [7:0] v, input int i);
      return v[i];
   endfunction

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 19200, serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, >=8).
REQ-004 SHALL have parameter DATA_BITS, default 8, character width (5..8).
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-007 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >=2).
REQ-008 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-009 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-010 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-011 SHALL have port data  output  DATA_BITS  FIFO head character.
REQ-012 SHALL have port valid  output  1  FIFO non-empty; data is meaningful.
REQ-013 SHALL have port ready  input  1  consumer pops head when valid&ready.
REQ-014 SHALL have port count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have ports frame_err, parity_err, overrun  output  1 each  sticky error flags.
REQ-016 SHALL have port clear_err  input  1  clears all sticky flags on the next edge.

Function
REQ-017 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-018 SHALL generate a sample tick every DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)) clocks (52 at defaults); divider free-runs while not IDLE and restarts on start detection.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-020 IDLE->START on synchronised rx falling edge; START->IDLE if the mid-bit vote is high (false start), else ->DATA.
REQ-021 SHALL determine every bit by 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 of that bit.
REQ-022 SHALL shift DATA_BITS bits LSB first; DATA->PARITY if PARITY!=0, else ->STOP.
REQ-023 PARITY SHALL compare the received bit with odd/even parity over the data bits; mismatch sets parity_err.
REQ-024 STOP SHALL check STOP_BITS stop bits; any low stop bit sets frame_err and enters WAIT_HIGH, else ->IDLE.
REQ-025 WAIT_HIGH SHALL hold until synchronised rx is high for one full sample tick (break handling), then ->IDLE.
REQ-026 A character with parity or frame error SHALL be discarded, never written to the FIFO.
REQ-027 A good character SHALL be pushed exactly one clock after the final stop-bit vote; valid rises on the following clock if the FIFO was empty.
REQ-028 FIFO SHALL be first-word-fall-through; data SHALL be stable while valid&!ready.
REQ-029 Push while full SHALL drop the character and set overrun; push and pop in the same cycle while full SHALL both succeed, count unchanged.
REQ-030 Pop while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-031 clear_err coincident with a new error event SHALL leave that flag set.

Reset
REQ-032 Reset asserted SHALL force state IDLE, FIFO empty, valid=0, count=0, data=0, all error flags 0, synchroniser flops 1.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; after release the next falling edge starts a fresh frame.

Structure
REQ-034 SHALL place the state enumeration and parity mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) in shared package uart_pkg.
REQ-035 SHALL instantiate FIFO storage as sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-036 Defaults, send 0x31 then 0x32 at 19200 baud, ready=0 -> count=2; then ready=1 pops 0x31, then 0x32; valid=0 after.
REQ-037 rx low for 3 sample ticks only -> no character, count=0, no flags, state back to IDLE.
REQ-038 PARITY=2, send 0x31 with parity bit 0 (wrong, correct is 1) -> parity_err=1, count=0; clear_err -> parity_err=0.
REQ-039 ready=0, send 17 characters 0x00..0x10 -> count=16, overrun=1; pops yield 0x00..0x0F.
REQ-040 Send 0x55 with stop bit low, then rx held low 2 frame times -> frame_err=1, count=0; after rx high, 0x41 received correctly.
REQ-041 Assert reset during bit 4 of 0x31 with FIFO holding 1 entry -> count=0, valid=0, flags 0; subsequent 0x32 received alone.
